// File: rtl/wasm_ctrl_frame_stack_pkg.sv
// Shared encodings and frame field positions for the WASM control-frame stack.
// Frame layout: {type[DATA_W-1 -: 2], spare, stack_tag[ADDR_W +: SP_W], addr_tag[ADDR_W-1:0]}.
package wasm_ctrl_pkg;

  typedef enum logic [1:0] {
    FT_BLOCK = 2'b00,
    FT_CALL  = 2'b01,
    FT_IF    = 2'b10,
    FT_LOOP  = 2'b11
  } frame_type_e;

  localparam int FT_W         = 2;
  localparam int ADDR_TAG_LSB = 0;

  function automatic int stack_tag_lsb(input int addr_w);
    return ADDR_TAG_LSB + addr_w;
  endfunction

  function automatic int type_lsb(input int data_w);
    return data_w - FT_W;
  endfunction

endpackage

// File: rtl/wasm_ctrl_frame_stack_if.sv
// Operation/read bundle between decode-execute and the control-frame stack.
// master issues operations and consumes reads; slave is the stack itself.
interface wasm_ctrl_frame_stack_if #(
  parameter int DEPTH      = 32,
  parameter int FUNC_DEPTH = 16,
  parameter int DATA_W     = 30,
  parameter int SP_W       = 6,
  parameter int ADDR_W     = 12
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FUNC_DEPTH) + 1;

  logic              shift_vld;
  logic              push;
  logic [PW-1:0]     pop_num;
  logic              retu;
  logic              func_call;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;

  logic [DATA_W-1:0] top_data;
  logic [PW-1:0]     depth;
  logic              left_one;
  logic [FW-1:0]     func_depth;
  logic [SP_W-1:0]   func_stack_tag;
  logic [ADDR_W-1:0] func_addr_tag;
  logic              ovf_err;
  logic              udf_err;
  logic [PW-1:0]     hwm;

  modport master (
    output shift_vld, push, pop_num, retu, func_call, push_data, err_clr,
    input  top_data, depth, left_one, func_depth, func_stack_tag, func_addr_tag,
           ovf_err, udf_err, hwm
  );

  modport slave (
    input  shift_vld, push, pop_num, retu, func_call, push_data, err_clr,
    output top_data, depth, left_one, func_depth, func_stack_tag, func_addr_tag,
           ovf_err, udf_err, hwm
  );
endinterface

// File: rtl/wasm_ctrl_frame_stack_func_list.sv
// Function-pointer list: frame index of each live call frame, innermost on top.
// Zero-latency fptr/fptr2 reads; updates only on commit, never stalls.
module wasm_ctrl_func_list #(
  parameter int FUNC_DEPTH = 16,
  parameter int PW         = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               commit,
  input  logic                               ret,
  input  logic                               wr_en,
  input  logic [PW-1:0]                      wr_ptr,
  output logic [$clog2(FUNC_DEPTH):0]        func_depth,
  output logic [PW-1:0]                      fptr,
  output logic [PW-1:0]                      fptr2
);
  localparam int FW = $clog2(FUNC_DEPTH) + 1;
  localparam int IW = FW - 1;

  logic [PW-1:0] flist [FUNC_DEPTH];
  logic [FW-1:0] fd_q;
  logic [IW-1:0] wr_slot, idx1, idx2;

  // Slot indices wrap modulo FUNC_DEPTH so a full list still addresses its top entry.
  assign wr_slot = fd_q[IW-1:0] - IW'(ret);
  assign idx1    = fd_q[IW-1:0] - IW'(1);
  assign idx2    = fd_q[IW-1:0] - IW'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      fd_q <= '0;
    end else if (commit) begin
      fd_q <= fd_q - FW'(ret) + FW'(wr_en);
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_en) begin
      flist[wr_slot] <= wr_ptr;
    end
  end

  assign func_depth = fd_q;
  assign fptr       = (fd_q != '0)     ? flist[idx1] : '0;
  assign fptr2      = (fd_q >= FW'(2)) ? flist[idx2] : '0;

endmodule

// File: rtl/wasm_ctrl_frame_stack.sv
// Control-frame stack: multi-pop / return / push / call per cycle; optional hwm via WASM_CTRL_STACK_WATERMARK_EN.
// Reads are combinational (zero latency); state commits on the clk edge when shift_vld=1.
// No backpressure: erroneous operations are dropped and flagged in sticky ovf_err/udf_err.
module wasm_ctrl_frame_stack
  import wasm_ctrl_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int FUNC_DEPTH = 16,
  parameter int DATA_W     = 30,
  parameter int SP_W       = 6,
  parameter int ADDR_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  wasm_ctrl_frame_stack_if.slave   bus
);
  localparam int PW      = $clog2(DEPTH) + 1;
  localparam int FW      = $clog2(FUNC_DEPTH) + 1;
  localparam int AW      = PW - 1;
  localparam int STK_LSB = stack_tag_lsb(ADDR_W);

  logic [DATA_W-1:0] entry [DEPTH];
  logic [PW-1:0]     depth_q, tap, nxt, fptr, fptr2;
  logic [FW-1:0]     fd;
  logic [FW:0]       fd_next;
  logic              call_push, func_return, udf, ovf, commit;
  logic              ovf_q, udf_q, rd_ok;
  logic [AW-1:0]     rd_idx;

  always_comb begin
    call_push   = bus.func_call & bus.push;
    tap         = bus.retu ? fptr : depth_q - bus.pop_num;
    func_return = bus.retu | ((bus.pop_num != '0) & (tap <= fptr) & (fd != '0));
    nxt         = tap + PW'(bus.push);
    fd_next     = {1'b0, fd} - (FW+1)'(func_return) + (FW+1)'(call_push);
    // A plain pop may leave at most one function; reaching past fptr2 would orphan the outer caller.
    udf         = (!bus.retu && (bus.pop_num > depth_q))
                | (bus.retu && (fd == '0))
                | ((fd >= FW'(2)) && (tap <= fptr2));
    ovf         = (bus.push && (tap == PW'(DEPTH)))
                | (call_push && (fd_next > (FW+1)'(FUNC_DEPTH)));
    commit      = bus.shift_vld & ~udf & ~ovf;
  end

  wasm_ctrl_func_list #(
    .FUNC_DEPTH (FUNC_DEPTH),
    .PW         (PW)
  ) u_func_list (
    .clk        (clk),
    .rst        (rst),
    .commit     (commit),
    .ret        (func_return),
    .wr_en      (call_push),
    .wr_ptr     (tap),
    .func_depth (fd),
    .fptr       (fptr),
    .fptr2      (fptr2)
  );

  always_ff @(posedge clk) begin
    if (commit && bus.push) begin
      entry[tap[AW-1:0]] <= bus.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (commit) begin
        depth_q <= nxt;
      end
      ovf_q <= (ovf_q & ~bus.err_clr) | (bus.shift_vld & ovf);
      udf_q <= (udf_q & ~bus.err_clr) | (bus.shift_vld & udf);
    end
  end

  always_comb begin
    rd_ok  = bus.retu ? (fd != '0) : (depth_q != '0);
    rd_idx = bus.retu ? fptr[AW-1:0] : depth_q[AW-1:0] - AW'(1);
  end

  assign bus.top_data       = rd_ok ? entry[rd_idx] : '0;
  assign bus.func_stack_tag = (fd != '0) ? entry[fptr[AW-1:0]][STK_LSB +: SP_W] : '0;
  assign bus.func_addr_tag  = (fd != '0) ? entry[fptr[AW-1:0]][ADDR_TAG_LSB +: ADDR_W] : '0;
  assign bus.depth          = depth_q;
  assign bus.left_one       = (depth_q == PW'(1));
  assign bus.func_depth     = fd;
  assign bus.ovf_err        = ovf_q;
  assign bus.udf_err        = udf_q;

`ifdef WASM_CTRL_STACK_WATERMARK_EN
  logic [PW-1:0] hwm_q, hwm_base;

  assign hwm_base = bus.err_clr ? '0 : hwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (commit && (nxt > hwm_base)) begin
      hwm_q <= nxt;
    end else begin
      hwm_q <= hwm_base;
    end
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif

endmodule

// File: tb/tb_wasm_ctrl_frame_stack.sv
// Directed bench for wasm_ctrl_frame_stack: push/pop, call/return, nesting, overflow, underflow, reset.
module tb_wasm_ctrl_frame_stack;
  import wasm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wasm_ctrl_frame_stack_if #(
    .DEPTH(32), .FUNC_DEPTH(16), .DATA_W(30), .SP_W(6), .ADDR_W(12)
  ) bus ();

  wasm_ctrl_frame_stack #(
    .DEPTH(32), .FUNC_DEPTH(16), .DATA_W(30), .SP_W(6), .ADDR_W(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] mk(input logic [1:0] t, input int sp, input int ad);
    logic [5:0]  s;
    logic [11:0] a;
    s = sp[5:0];
    a = ad[11:0];
    return {t, 10'b0, s, a};
  endfunction

  task automatic idle();
    bus.shift_vld = 1'b0;
    bus.push      = 1'b0;
    bus.pop_num   = '0;
    bus.retu      = 1'b0;
    bus.func_call = 1'b0;
    bus.push_data = '0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One committed-attempt cycle; outputs are sampled 1 time unit after the edge.
  task automatic op(input logic ps, input int pn, input logic rt, input logic fc,
                    input logic [29:0] d, input logic ec = 1'b0);
    logic [5:0] p;
    p = pn[5:0];
    bus.shift_vld = 1'b1;
    bus.push      = ps;
    bus.pop_num   = p;
    bus.retu      = rt;
    bus.func_call = fc;
    bus.push_data = d;
    bus.err_clr   = ec;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [29:0] fa, fb, fc_, fx, fy;

  initial begin
    fa  = mk(FT_BLOCK, 0, 'h101);
    fb  = mk(FT_BLOCK, 0, 'h102);
    fc_ = mk(FT_BLOCK, 0, 'h103);
    fx  = mk(FT_CALL, 5, 'h040);
    fy  = mk(FT_CALL, 7, 'h080);

    do_reset();
    check_eq("rst_depth", 32'(bus.depth), 0);
    check_eq("rst_fdepth", 32'(bus.func_depth), 0);
    check_eq("rst_ovf", 32'(bus.ovf_err), 0);
    check_eq("rst_udf", 32'(bus.udf_err), 0);
    check_eq("rst_hwm", 32'(bus.hwm), 0);
    check_eq("rst_top", 32'(bus.top_data), 0);
    check_eq("rst_stag", 32'(bus.func_stack_tag), 0);
    check_eq("rst_atag", 32'(bus.func_addr_tag), 0);
    check_eq("rst_left_one", 32'(bus.left_one), 0);

    op(1, 0, 0, 0, fa);
    op(1, 0, 0, 0, fb);
    op(1, 0, 0, 0, fc_);
    check_eq("push3_depth", 32'(bus.depth), 3);
    check_eq("push3_top", 32'(bus.top_data), 32'(fc_));
    op(0, 2, 0, 0, '0);
    check_eq("pop2_depth", 32'(bus.depth), 1);
    check_eq("pop2_left_one", 32'(bus.left_one), 1);
    check_eq("pop2_top", 32'(bus.top_data), 32'(fa));

    // Single call, two blocks, then return.
    op(1, 0, 0, 1, fx);
    check_eq("call_fdepth", 32'(bus.func_depth), 1);
    check_eq("call_stag", 32'(bus.func_stack_tag), 5);
    check_eq("call_atag", 32'(bus.func_addr_tag), 'h40);
    op(1, 0, 0, 0, fb);
    op(1, 0, 0, 0, fc_);
    check_eq("call_blk_depth", 32'(bus.depth), 4);
    bus.shift_vld = 1'b1;
    bus.retu      = 1'b1;
    #1;
    check_eq("retu_top", 32'(bus.top_data), 32'(fx));
    check_eq("retu_stag", 32'(bus.func_stack_tag), 5);
    check_eq("retu_atag", 32'(bus.func_addr_tag), 'h40);
    tick();
    idle();
    check_eq("retu_depth", 32'(bus.depth), 1);
    check_eq("retu_fdepth", 32'(bus.func_depth), 0);
    check_eq("retu_stag_zero", 32'(bus.func_stack_tag), 0);

    // Nested calls: frames A X b Y b at indices 0..4, flist = {1, 3}.
    op(1, 0, 0, 1, fx);
    op(1, 0, 0, 0, fb);
    op(1, 0, 0, 1, fy);
    op(1, 0, 0, 0, fb);
    check_eq("nest_fdepth", 32'(bus.func_depth), 2);
    check_eq("nest_stag", 32'(bus.func_stack_tag), 7);
    op(0, 4, 0, 0, '0);
    check_eq("cross_udf", 32'(bus.udf_err), 1);
    check_eq("cross_ovf", 32'(bus.ovf_err), 0);
    check_eq("cross_depth", 32'(bus.depth), 5);
    check_eq("cross_fdepth", 32'(bus.func_depth), 2);
    op(0, 2, 0, 0, '0);
    check_eq("popret_depth", 32'(bus.depth), 3);
    check_eq("popret_fdepth", 32'(bus.func_depth), 1);
    check_eq("popret_stag", 32'(bus.func_stack_tag), 5);
    bus.err_clr = 1'b1;
    tick();
    idle();
    check_eq("udf_clr", 32'(bus.udf_err), 0);

    // retu with no live function is an underflow.
    do_reset();
    op(1, 0, 0, 0, fa);
    op(0, 0, 1, 0, '0);
    check_eq("retu_nofunc_udf", 32'(bus.udf_err), 1);
    check_eq("retu_nofunc_depth", 32'(bus.depth), 1);

    // Fill to DEPTH.
    do_reset();
    for (int i = 0; i < 32; i++) op(1, 0, 0, 0, mk(FT_BLOCK, 0, i));
    check_eq("full_depth", 32'(bus.depth), 32);
    check_eq("full_top", 32'(bus.top_data), 31);
    op(1, 0, 0, 0, mk(FT_LOOP, 0, 'h3FF));
    check_eq("full_ovf", 32'(bus.ovf_err), 1);
    check_eq("full_ovf_depth", 32'(bus.depth), 32);
    check_eq("full_ovf_top", 32'(bus.top_data), 31);
    bus.err_clr = 1'b1;
    tick();
    idle();
    check_eq("full_clr", 32'(bus.ovf_err), 0);
    op(1, 1, 0, 0, mk(FT_BLOCK, 0, 'h3FF));
    check_eq("full_swap_ovf", 32'(bus.ovf_err), 0);
    check_eq("full_swap_depth", 32'(bus.depth), 32);
    check_eq("full_swap_top", 32'(bus.top_data), 'h3FF);

    // Function list capacity.
    do_reset();
    for (int i = 0; i < 16; i++) op(1, 0, 0, 1, mk(FT_CALL, i, i));
    check_eq("f16_fdepth", 32'(bus.func_depth), 16);
    check_eq("f16_stag", 32'(bus.func_stack_tag), 15);
    check_eq("f16_atag", 32'(bus.func_addr_tag), 15);
    op(1, 0, 0, 1, mk(FT_CALL, 16, 16));
    check_eq("f17_ovf", 32'(bus.ovf_err), 1);
    check_eq("f17_fdepth", 32'(bus.func_depth), 16);
    check_eq("f17_depth", 32'(bus.depth), 16);
    bus.err_clr = 1'b1;
    tick();
    idle();
    check_eq("f17_clr", 32'(bus.ovf_err), 0);
    op(1, 0, 0, 1, mk(FT_CALL, 16, 16), 1'b1);
    check_eq("clr_set_wins", 32'(bus.ovf_err), 1);
    op(0, 0, 1, 0, '0);
    check_eq("f16_retu_depth", 32'(bus.depth), 15);
    check_eq("f16_retu_fdepth", 32'(bus.func_depth), 15);
    check_eq("f16_retu_stag", 32'(bus.func_stack_tag), 14);

    // Watermark, then reset dominating a live operation.
    do_reset();
    for (int i = 0; i < 7; i++) op(1, 0, 0, 0, mk(FT_IF, 0, i));
    op(0, 5, 0, 0, '0);
    check_eq("wm_depth", 32'(bus.depth), 2);
`ifdef WASM_CTRL_STACK_WATERMARK_EN
    check_eq("wm_hwm", 32'(bus.hwm), 7);
`else
    check_eq("wm_hwm", 32'(bus.hwm), 0);
`endif
    op(0, 5, 0, 0, '0);
    check_eq("wm_udf", 32'(bus.udf_err), 1);
    rst           = 1'b1;
    bus.shift_vld = 1'b1;
    bus.push      = 1'b1;
    bus.func_call = 1'b1;
    bus.push_data = fx;
    tick();
    idle();
    rst = 1'b0;
    check_eq("rst2_depth", 32'(bus.depth), 0);
    check_eq("rst2_fdepth", 32'(bus.func_depth), 0);
    check_eq("rst2_udf", 32'(bus.udf_err), 0);
    check_eq("rst2_hwm", 32'(bus.hwm), 0);
    check_eq("rst2_top", 32'(bus.top_data), 0);
    check_eq("rst2_left_one", 32'(bus.left_one), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wasm_ctrl_frame_stack.md
# wasm_ctrl_frame_stack

Parametrised control-frame stack for the WASM core: it holds block/loop/if/call frames and keeps a nested list of function-frame pointers. Each operation can pop several frames, unwind a function return, push one frame and open a function, all in one shift cycle. Overflow and underflow are detected and the offending operation is discarded. It sits beside the operand stack in the decode/execute stage and supplies branch targets and function stack/address tags.

## Interface
- DEPTH, 32: frame entries; power of two, ≥2
- FUNC_DEPTH, 16: maximum nested live function frames; power of two
- DATA_W, 30: frame width; ≥ SP_W+ADDR_W+2
- SP_W, 6: operand-stack tag width
- ADDR_W, 12: instruction-address tag width
- Derived: PW = log2(DEPTH)+1, FW = log2(FUNC_DEPTH)+1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- shift_vld  in  1  commit current operation at clk edge
- push  in  1  push push_data after the pop phase
- pop_num  in  PW  frames to pop (0..DEPTH); br N drives N+1
- retu  in  1  unwind to, and including, the innermost call frame (overrides pop_num)
- func_call  in  1  pushed frame opens a function; valid only with push
- push_data  in  DATA_W  frame {type[DATA_W-1:DATA_W-2], …, stack_tag, addr_tag}
- err_clr  in  1  clears sticky errors and watermark
- top_data  out  DATA_W  frame read for the current operation
- depth  out  PW  occupied frames
- left_one  out  1  depth == 1
- func_depth  out  FW  live function frames
- func_stack_tag  out  SP_W  bits [SP_W+ADDR_W-1:ADDR_W] of the innermost call frame
- func_addr_tag  out  ADDR_W  bits [ADDR_W-1:0] of the innermost call frame
- ovf_err, udf_err  out  1  sticky error flags
- hwm  out  PW  high-watermark of depth (see Configuration)

## Operation
- fptr = stored index of the innermost call frame; fptr2 = the next call frame out.
- pop phase: tap = retu ? fptr : depth − pop_num.
- push phase: next = tap + push. When push is set, entry[tap] ← push_data.
- func_return = retu | (pop_num≠0 & tap ≤ fptr & func_depth≠0).
- When func_call & push: flist[func_depth − func_return] ← tap.
- func_depth_next = func_depth − func_return + (func_call & push). func_call without push is ignored and raises no error.
- Reads:
  - retu=1: top_data = entry[fptr].
  - otherwise: top_data = entry[depth−1], or 0 if depth=0.
  - func_*_tag = 0 when func_depth=0.
- Underflow, when any of these holds: pop_num > depth; retu with func_depth=0; a pop that crosses two function frames (func_depth≥2 & tap ≤ fptr2). On underflow: udf_err←1 and no state changes.
- Overflow, when any of these holds: push & tap = DEPTH; func_call & push & func_depth_next > FUNC_DEPTH. On overflow: ovf_err←1 and no state changes.
- If both conditions hold, both flags set.
- Frame storage is not reset. All reads are guarded by depth/func_depth.

## Timing
- All outputs are combinational from state and current inputs. Latency is zero for reads, and state updates on the clk edge when shift_vld=1.
- With shift_vld=0, state holds, but top_data still tracks retu.
- Reset values: depth=0, func_depth=0, ovf_err=0, udf_err=0, hwm=0, top_data=0, tags=0, left_one=0.
- rst dominates shift_vld and err_clr; reset mid-program discards all frames.
- err_clr with shift_vld in the same cycle: flags clear, and any new error from that operation sets them again (set wins).
- Back-to-back operations on every cycle are supported. There is no stall path.

## Configuration
- WASM_CTRL_STACK_WATERMARK_EN defined:
  - hwm ← max(hwm, next) on each committed operation.
  - Cleared by rst or err_clr.
- Undefined: hwm is tied to 0 and the comparator is absent. The port is always present.

## Structure
- Shared package wasm_ctrl_pkg holds:
  - frame-type encodings: FT_BLOCK=2'b00, FT_CALL=2'b01, FT_IF=2'b10, FT_LOOP=2'b11
  - field-position localparams for type, stack_tag and addr_tag
- One sub-module, wasm_ctrl_func_list. It is the function-pointer list: it holds flist and func_depth and produces fptr/fptr2, with write/return inputs.

## Test plan
- Defaults, reset, then push A,B,C (FT_BLOCK) → depth=3, top_data=C. Then pop_num=2 → depth=1, left_one=1, top_data=A.
- push call frame X (func_call, stack_tag=5, addr_tag=0x40), then push 2 blocks, then retu=1 → top_data=X during the cycle, func_stack_tag=5, func_addr_tag=0x40. After the edge: depth = pre-call depth, func_depth=0.
- Nested calls X then Y, each followed by 1 block. A pop_num that crosses both call frames → udf_err=1, depth and func_depth unchanged.
- Fill to 32, then push → ovf_err=1 and depth stays 32. Same cycle pop_num=1 & push → accepted, no error.
- 17th nested func_call → ovf_err=1. Then err_clr → ovf_err=0.
- With WASM_CTRL_STACK_WATERMARK_EN: push 7, pop 5 → hwm=7. rst asserted with shift_vld=1 → all outputs 0 next cycle.
